// File: rtl/collision_scheduler.sv
// Shares one external rectangle-overlap checker across N_REQ hitboxes per frame:
// snapshot on start, issue one check per cycle, gather results, publish hits_o.
module collision_scheduler #(
    parameter int N_REQ   = 6,
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int CMP_LAT = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            start_i,
    input  logic                            abort_i,
    input  logic [N_REQ-1:0]                req_mask_i,
    input  logic [N_REQ*(2*X_W+2*Y_W)-1:0]  rects_i,
    input  logic [2*X_W+2*Y_W-1:0]          ball_i,
    output logic                            cmp_valid_o,
    output logic [2*X_W+2*Y_W-1:0]          cmp_a_o,
    output logic [2*X_W+2*Y_W-1:0]          cmp_b_o,
    input  logic                            cmp_hit_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [N_REQ-1:0]                hits_o,
    output logic                            overrun_o
);
    localparam int RECT_W = 2*X_W + 2*Y_W;
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W  = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_next;

    logic [RECT_W-1:0]  snap_rect [N_REQ];
    logic [RECT_W-1:0]  snap_ball;
    logic [N_REQ-1:0]   snap_mask;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   drain_cnt;
    logic [N_REQ-1:0]   scratch, scratch_next;
    logic [CMP_LAT-1:0] tag_valid;
    logic [IDX_W-1:0]   tag_idx [CMP_LAT];
    logic               issuing, accept, last_idx, last_drain;

    assign issuing    = (state == ISSUE);
    assign busy_o     = (state == ISSUE) || (state == DRAIN);
    assign done_o     = (state == DONE);
    assign accept     = start_i && !abort_i && ((state == IDLE) || (state == DONE));
    assign last_idx   = (idx == IDX_W'(N_REQ-1));
    assign last_drain = (drain_cnt == CNT_W'(CMP_LAT-1));

    assign cmp_valid_o = issuing && snap_mask[idx];
    assign cmp_a_o     = issuing ? snap_rect[idx] : '0;
    assign cmp_b_o     = issuing ? snap_ball : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = accept ? ISSUE : IDLE;
            ISSUE: begin
                if (abort_i)       state_next = IDLE;
                else if (last_idx) state_next = DRAIN;
            end
            DRAIN: begin
                if (abort_i)         state_next = IDLE;
                else if (last_drain) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The result landing in the final drain cycle is merged before publishing.
    always_comb begin
        scratch_next = scratch;
        if (tag_valid[CMP_LAT-1])
            scratch_next[tag_idx[CMP_LAT-1]] = cmp_hit_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < N_REQ; i++) snap_rect[i] <= '0;
            for (int unsigned i = 0; i < CMP_LAT; i++) tag_idx[i] <= '0;
            snap_ball <= '0;
            snap_mask <= '0;
            idx       <= '0;
            drain_cnt <= '0;
            scratch   <= '0;
            tag_valid <= '0;
            hits_o    <= '0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= start_i && !abort_i && busy_o;

            if (accept) begin
                for (int unsigned i = 0; i < N_REQ; i++)
                    snap_rect[i] <= rects_i[i*RECT_W +: RECT_W];
                snap_ball <= ball_i;
                snap_mask <= req_mask_i;
                scratch   <= '0;
                idx       <= '0;
            end else begin
                scratch <= scratch_next;
                if (issuing && !last_idx) idx <= idx + 1'b1;
            end

            if (state != DRAIN)   drain_cnt <= '0;
            else if (!last_drain) drain_cnt <= drain_cnt + 1'b1;

            if (abort_i && busy_o) begin
                tag_valid <= '0;
            end else begin
                tag_valid[0] <= cmp_valid_o;
                tag_idx[0]   <= idx;
                for (int unsigned i = 1; i < CMP_LAT; i++) begin
                    tag_valid[i] <= tag_valid[i-1];
                    tag_idx[i]   <= tag_idx[i-1];
                end
            end

            if ((state == DRAIN) && last_drain && !abort_i)
                hits_o <= scratch_next;
        end
    end
endmodule

// File: tb/tb_collision_scheduler.sv
// Bench for collision_scheduler: two instances (checker latency 1 and 3) on shared
// stimulus, a latency-accurate checker emulation each, and a frame-level reference model.
module tb_collision_scheduler;
    localparam int N  = 6;
    localparam int XW = 10;
    localparam int RW = 4*XW;
    localparam int LA = 1;
    localparam int LB = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic start, abort;
    logic [N-1:0] mask;
    logic [N*RW-1:0] rects;
    logic [RW-1:0] ball;

    logic valid_a, busy_a, done_a, ovr_a, hit_a;
    logic valid_b, busy_b, done_b, ovr_b, hit_b;
    logic [RW-1:0] a_a, b_a, a_b, b_b;
    logic [N-1:0] hits_a, hits_b;

    bit force_hit, noise_en;
    int n_cmp, n_bad, cyc;

    // frame-level reference state, index 0 = latency-1 instance, 1 = latency-3
    int ts [2];
    bit active [2];
    bit exp_done [2];
    bit exp_ovr [2];
    logic [N-1:0] exp_hits [2];
    logic [N-1:0] scan_hits [2];
    logic [N-1:0] m_mask [2];
    logic [N*RW-1:0] m_rects [2];
    logic [RW-1:0] m_ball [2];

    typedef struct {
        logic [N-1:0] mask;
        logic [N-1:0] ovl;
        bit           force_on;
        logic [N-1:0] exp_hits;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    collision_scheduler #(.N_REQ(N), .X_W(XW), .Y_W(XW), .CMP_LAT(LA)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .req_mask_i(mask), .rects_i(rects), .ball_i(ball),
        .cmp_valid_o(valid_a), .cmp_a_o(a_a), .cmp_b_o(b_a), .cmp_hit_i(hit_a),
        .busy_o(busy_a), .done_o(done_a), .hits_o(hits_a), .overrun_o(ovr_a));

    collision_scheduler #(.N_REQ(N), .X_W(XW), .Y_W(XW), .CMP_LAT(LB)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .req_mask_i(mask), .rects_i(rects), .ball_i(ball),
        .cmp_valid_o(valid_b), .cmp_a_o(a_b), .cmp_b_o(b_b), .cmp_hit_i(hit_b),
        .busy_o(busy_b), .done_o(done_b), .hits_o(hits_b), .overrun_o(ovr_b));

    function automatic logic [RW-1:0] mk_rect(int x, int y, int w, int h);
        return {XW'(x), XW'(y), XW'(x + w), XW'(y + h)};
    endfunction

    // inclusive-edge overlap of {x, y, right, bottom} rectangles
    function automatic bit overlaps(logic [RW-1:0] p, logic [RW-1:0] q);
        return (p[39:30] <= q[19:10]) && (q[39:30] <= p[19:10]) &&
               (p[29:20] <= q[9:0])   && (q[29:20] <= p[9:0]);
    endfunction

    function automatic logic [N-1:0] ref_hits(logic [N-1:0] m, logic [N*RW-1:0] r,
                                               logic [RW-1:0] b, bit f);
        logic [N-1:0] h = '0;
        for (int k = 0; k < N; k++)
            h[k] = m[k] && (f || overlaps(r[k*RW +: RW], b));
        return h;
    endfunction

    // external checker emulation: fixed latency, noise when nothing is in flight
    bit dv_a [LA], dr_a [LA], dv_b [LB], dr_b [LB];
    bit noise_a, noise_b;
    always @(posedge clk) begin
        dv_a[0] <= valid_a;
        dr_a[0] <= force_hit || overlaps(a_a, b_a);
        for (int i = 1; i < LA; i++) begin dv_a[i] <= dv_a[i-1]; dr_a[i] <= dr_a[i-1]; end
        dv_b[0] <= valid_b;
        dr_b[0] <= force_hit || overlaps(a_b, b_b);
        for (int i = 1; i < LB; i++) begin dv_b[i] <= dv_b[i-1]; dr_b[i] <= dr_b[i-1]; end
        noise_a <= 1'($urandom_range(0, 1));
        noise_b <= 1'($urandom_range(0, 1));
    end
    assign hit_a = dv_a[LA-1] ? dr_a[LA-1] : (noise_en ? noise_a : force_hit);
    assign hit_b = dv_b[LB-1] ? dr_b[LB-1] : (noise_en ? noise_b : force_hit);

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    function automatic int lat(int d);
        return (d == 0) ? LA : LB;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            active[d] = 0; ts[d] = 0; exp_done[d] = 0; exp_ovr[d] = 0;
            exp_hits[d] = '0; scan_hits[d] = '0;
        end
    endtask

    // advance the reference model across the edge ending the current cycle
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int l = lat(d);
            bit busy_c = active[d] && cyc >= ts[d] + 1 && cyc <= ts[d] + N + l;
            exp_ovr[d] = busy_c && start && !abort;
            if (busy_c && abort) begin
                active[d] = 0;
            end else if (!busy_c && start && !abort) begin
                ts[d] = cyc; active[d] = 1;
                m_mask[d] = mask; m_rects[d] = rects; m_ball[d] = ball;
                scan_hits[d] = ref_hits(mask, rects, ball, force_hit);
            end
            exp_done[d] = active[d] && (cyc + 1 == ts[d] + N + l + 1);
            if (exp_done[d]) exp_hits[d] = scan_hits[d];
        end
    endtask

    task automatic check_dut(int d, logic v, logic [RW-1:0] ca, logic [RW-1:0] cb,
                             logic bz, logic dn, logic [N-1:0] h, logic ov);
        int l = lat(d);
        int k = cyc - ts[d] - 1;
        bit iss = active[d] && k >= 0 && k < N;
        bit exp_v = iss && m_mask[d][k];
        string tag = (d == 0) ? "lat1" : "lat3";
        chk({tag, "_busy"}, 64'(bz), 64'(active[d] && k >= 0 && k < N + l));
        chk({tag, "_valid"}, 64'(v), 64'(exp_v));
        chk({tag, "_done"}, 64'(dn), 64'(exp_done[d]));
        chk({tag, "_overrun"}, 64'(ov), 64'(exp_ovr[d]));
        chk({tag, "_hits"}, 64'(h), 64'(exp_hits[d]));
        if (exp_v) begin
            chk({tag, "_cmp_a"}, 64'(ca), 64'(m_rects[d][k*RW +: RW]));
            chk({tag, "_cmp_b"}, 64'(cb), 64'(m_ball[d]));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_dut(0, valid_a, a_a, b_a, busy_a, done_a, hits_a, ovr_a);
        check_dut(1, valid_b, a_b, b_b, busy_b, done_b, hits_b, ovr_b);
    endtask

    task automatic set_scene(logic [N-1:0] ovl);
        ball = mk_rect(100, 100, 8, 8);
        for (int k = 0; k < N; k++)
            rects[k*RW +: RW] = ovl[k] ? mk_rect(96 + k, 90, 10, 40)
                                       : mk_rect(300 + 20*k, 300, 10, 10);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'({busy_a, busy_b}), 64'(0));
        chk("rst_done", 64'({done_a, done_b}), 64'(0));
        chk("rst_valid", 64'({valid_a, valid_b}), 64'(0));
        chk("rst_hits", 64'({hits_a, hits_b}), 64'(0));
        chk("rst_overrun", 64'({ovr_a, ovr_b}), 64'(0));
        chk("rst_cmp_ab", 64'(a_a | b_a | a_b | b_b), 64'(0));
        model_clear();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (i == 1) rst_n = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, dones;
        vecs[0] = '{6'h3F,     6'b000100, 1'b0, 6'b000100};
        vecs[1] = '{6'b101010, 6'b000000, 1'b1, 6'b101010};
        vecs[2] = '{6'h3F,     6'h3F,     1'b0, 6'h3F};
        vecs[3] = '{6'b010101, 6'h3F,     1'b0, 6'b010101};
        vecs[4] = '{6'h00,     6'h3F,     1'b1, 6'h00};
        vecs[5] = '{6'b100001, 6'b100000, 1'b0, 6'b100000};

        n_cmp = 0; n_bad = 0; cyc = 0;
        rst_n = 1'b0; start = 0; abort = 0; mask = '0; rects = '0; ball = '0;
        force_hit = 0; noise_en = 1;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) step();

        // table-driven single scans
        for (int i = 0; i < 6; i++) begin
            mask = vecs[i].mask; force_hit = vecs[i].force_on; set_scene(vecs[i].ovl);
            start = 1; step(); start = 0;
            repeat (N + LB + 2) step();
            chk("vec_hits_lat1", 64'(hits_a), 64'(vecs[i].exp_hits));
            chk("vec_hits_lat3", 64'(hits_b), 64'(vecs[i].exp_hits));
        end
        force_hit = 0;

        // snapshot: inputs change two cycles into the scan
        mask = 6'h3F; set_scene(6'b010010);
        start = 1; step(); start = 0;
        step();
        set_scene(6'b101101); ball = mk_rect(500, 500, 4, 4); mask = 6'h01;
        repeat (N + LB + 1) step();
        chk("snapshot_hits_lat1", 64'(hits_a), 64'(6'b010010));
        chk("snapshot_hits_lat3", 64'(hits_b), 64'(6'b010010));

        // overrun at t+3, restart in the done cycle t+8
        mask = 6'h3F; set_scene(6'b000100);
        t = cyc; dones = 0;
        start = 1; step(); start = 0;
        for (int c = 1; c <= 17; c++) begin
            if (c == 4)  chk("overrun_t4", 64'(ovr_a), 64'(1));
            if (c == 8)  chk("done_t8", 64'(done_a), 64'(1));
            if (c == 16) chk("done_t16", 64'(done_a), 64'(1));
            if (c <= 15) dones += int'(done_a);
            start = (c == 3) || (c == 8);
            step();
            start = 0;
        end
        chk("single_done_first_scan", 64'(dones), 64'(1));

        // abort at t+4 with a stuck-high checker
        force_hit = 1; mask = 6'h3F; set_scene(6'h00);
        dones = 0;
        start = 1; step(); start = 0;
        for (int c = 1; c <= 15; c++) begin
            if (c == 5) chk("abort_busy_t5", 64'({busy_a, busy_b}), 64'(0));
            dones += int'(done_a) + int'(done_b);
            abort = (c == 4);
            step();
            abort = 0;
        end
        chk("abort_no_done", 64'(dones), 64'(0));
        chk("abort_hits_kept", 64'(hits_b), 64'(6'b000100));

        // abort and start on the same edge
        start = 1; abort = 1; step(); start = 0; abort = 0;
        chk("abort_start_idle", 64'({busy_a, busy_b, ovr_a, ovr_b}), 64'(0));
        force_hit = 0;
        repeat (2) step();

        // reset in the middle of a scan
        mask = 6'h3F; set_scene(6'h3F);
        start = 1; step(); start = 0;
        repeat (3) step();
        do_reset();
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            dones += int'(done_a) + int'(done_b);
        end
        chk("reset_no_done", 64'(dones), 64'(0));

        // randomized traffic against the frame-level model
        for (int i = 0; i < 2000; i++) begin
            start = ($urandom_range(0, 5) == 0);
            abort = ($urandom_range(0, 39) == 0);
            mask = N'($urandom);
            for (int k = 0; k < N; k++)
                rects[k*RW +: RW] = mk_rect($urandom_range(0, 60), $urandom_range(0, 60),
                                            $urandom_range(0, 20), $urandom_range(0, 20));
            ball = mk_rect($urandom_range(0, 60), $urandom_range(0, 60),
                           $urandom_range(2, 20), $urandom_range(2, 20));
            step();
        end
        start = 0; abort = 0;
        repeat (12) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
